// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
//   Shared types for the iterative TinyRV1 execute-stage ALU.
//   alu_op_t         : 2-bit operation select (ADD, EQ, SUB, MUL)
//   iter_alu_state_t : control FSM states (IDLE, CALC, DONE)
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_EQ  = 2'd1,
    ALU_SUB = 2'd2,
    ALU_MUL = 2'd3
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } iter_alu_state_t;

endpackage

// File: rtl/iter_alu_mul_step.sv
// -----------------------------------------------------------------------------
// iter_alu_mul_step
//   One combinational step of the shift-add multiplier.
//   Ports:
//     acc_i, a_i, b_i : current accumulator, shifted multiplicand, shifted multiplier
//     acc_o, a_o, b_o : values after this step (add if b[0], then a<<1, b>>1)
// -----------------------------------------------------------------------------
module iter_alu_mul_step #(
  parameter int nbits = 32
) (
  input  logic [nbits-1:0] acc_i,
  input  logic [nbits-1:0] a_i,
  input  logic [nbits-1:0] b_i,
  output logic [nbits-1:0] acc_o,
  output logic [nbits-1:0] a_o,
  output logic [nbits-1:0] b_o
);

  // Conditional add of the multiplicand, then advance both shift registers.
  always_comb begin
    acc_o = b_i[0] ? (acc_i + a_i) : acc_i;
    a_o   = a_i << 1;
    b_o   = b_i >> 1;
  end

endmodule

// File: rtl/iter_alu.sv
// -----------------------------------------------------------------------------
// iter_alu
//   Multi-cycle ALU with val/rdy handshakes on both request and result side.
//   ADD/EQ/SUB complete in one cycle; MUL iterates a shift-add step in CALC.
//   Ports:
//     clk, rst_n      : clock, asynchronous active-low reset
//     in_val, in_rdy  : request handshake (accepted only in IDLE)
//     op, in0, in1    : operation and operands
//     out_val, out_rdy: result handshake (result held in DONE until taken)
//     out             : result, modulo 2^nbits
//   Build option:
//     ITER_ALU_MUL_EARLY_EXIT_EN : leave CALC as soon as the remaining
//     multiplier bits are all zero. Results are unchanged, only latency.
// -----------------------------------------------------------------------------
module iter_alu
  import alu_pkg::*;
#(
  parameter int nbits = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [1:0]       op,
  input  logic [nbits-1:0] in0,
  input  logic [nbits-1:0] in1,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [nbits-1:0] out
);

  localparam int CW = $clog2(nbits + 1);
  localparam logic [CW-1:0] CntInit = CW'(nbits);
  localparam logic [CW-1:0] CntOne  = CW'(1);

  iter_alu_state_t state_q, state_d;
  logic [nbits-1:0] acc_q, acc_d;
  logic [nbits-1:0] a_q, a_d;
  logic [nbits-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [nbits-1:0] out_q, out_d;

  alu_op_t          opSel;
  logic             isSub;
  logic [nbits-1:0] addB;
  logic [nbits-1:0] addSum;
  logic             eqBit;
  logic [nbits-1:0] singleRes;
  logic [nbits-1:0] accNext, aNext, bNext;
  logic             mulFinish;

  assign opSel = alu_op_t'(op);

  // Single shared adder: SUB is formed as in0 + ~in1 + 1.
  always_comb begin
    isSub  = (opSel == ALU_SUB);
    addB   = isSub ? ~in1 : in1;
    addSum = in0 + addB + {{(nbits-1){1'b0}}, isSub};
    eqBit  = (in0 == in1);
  end

  // Result of the single-cycle operations, registered on acceptance.
  always_comb begin
    singleRes = addSum;
    if (opSel == ALU_EQ) begin
      singleRes = {{(nbits-1){1'b0}}, eqBit};
    end
  end

  iter_alu_mul_step #(.nbits(nbits)) uMulStep (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (accNext),
    .a_o   (aNext),
    .b_o   (bNext)
  );

  // CALC ends on the last counted step, or early once no multiplier bits remain.
  always_comb begin
`ifdef ITER_ALU_MUL_EARLY_EXIT_EN
    mulFinish = (cnt_q == CntOne) || (bNext == '0);
`else
    mulFinish = (cnt_q == CntOne);
`endif
  end

  // Next-state and handshake outputs; all defaults hold current state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    in_rdy  = 1'b0;
    out_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_rdy = 1'b1;
        if (in_val) begin
          if (opSel == ALU_MUL) begin
            acc_d   = '0;
            a_d     = in0;
            b_d     = in1;
            cnt_d   = CntInit;
            state_d = CALC;
          end else begin
            out_d   = singleRes;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d = accNext;
        a_d   = aNext;
        b_d   = bNext;
        cnt_d = cnt_q - CntOne;
        if (mulFinish) begin
          out_d   = accNext;
          state_d = DONE;
        end
      end
      DONE: begin
        out_val = 1'b1;
        if (out_rdy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_iter_alu.sv
// -----------------------------------------------------------------------------
// tb_iter_alu
//   Self-checking bench for iter_alu (nbits=32). A reference model tracks the
//   expected handshake phase and result from the op's arithmetic meaning and
//   its documented latency; a compare process checks every cycle. Directed
//   tests pin literal results and latencies. Honors ITER_ALU_MUL_EARLY_EXIT_EN.
// -----------------------------------------------------------------------------
module tb_iter_alu;

  localparam int NBITS = 32;
  localparam logic [1:0] OpAdd = 2'd0;
  localparam logic [1:0] OpEq  = 2'd1;
  localparam logic [1:0] OpSub = 2'd2;
  localparam logic [1:0] OpMul = 2'd3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_val = 1'b0;
  logic             in_rdy;
  logic [1:0]       op = 2'd0;
  logic [NBITS-1:0] in0 = '0;
  logic [NBITS-1:0] in1 = '0;
  logic             out_val;
  logic             out_rdy = 1'b0;
  logic [NBITS-1:0] out;

  int checks = 0;
  int failures = 0;
  bit cmpEn = 1'b0;

  always #5 clk = ~clk;

  iter_alu #(.nbits(NBITS)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .op      (op),
    .in0     (in0),
    .in1     (in1),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .out     (out)
  );

  // Arithmetic meaning of each op, modulo 2^32.
  function automatic logic [NBITS-1:0] refResult(input logic [1:0] o,
                                                 input logic [NBITS-1:0] a,
                                                 input logic [NBITS-1:0] b);
    logic [63:0] prod;
    case (o)
      OpAdd:   return a + b;
      OpEq:    return (a == b) ? 32'd1 : 32'd0;
      OpSub:   return a - b;
      default: begin
        prod = {32'd0, a} * {32'd0, b};
        return prod[NBITS-1:0];
      end
    endcase
  endfunction

  // Accept-to-first-out_val cycle count.
  function automatic int refLatency(input logic [1:0] o, input logic [NBITS-1:0] b);
    int msb;
    if (o != OpMul) return 1;
`ifdef ITER_ALU_MUL_EARLY_EXIT_EN
    msb = 0;
    for (int i = 0; i < NBITS; i++) if (b[i]) msb = i;
    return msb + 2;
`else
    return NBITS + 1;
`endif
  endfunction

  // Model phase: 0 = accepting, 1 = busy computing, 2 = presenting result.
  int               mPhase = 0;
  int               mRemain = 0;
  logic [NBITS-1:0] mPend = '0;
  logic [NBITS-1:0] mOut = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase  <= 0;
      mRemain <= 0;
      mPend   <= '0;
      mOut    <= '0;
    end else begin
      case (mPhase)
        0: if (in_val) begin
          if (refLatency(op, in1) == 1) begin
            mPhase <= 2;
            mOut   <= refResult(op, in0, in1);
          end else begin
            mPhase  <= 1;
            mRemain <= refLatency(op, in1) - 1;
            mPend   <= refResult(op, in0, in1);
          end
        end
        1: if (mRemain == 1) begin
          mPhase <= 2;
          mOut   <= mPend;
        end else begin
          mRemain <= mRemain - 1;
        end
        default: if (out_rdy) mPhase <= 0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [NBITS-1:0] act,
                             input logic [NBITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model_in_rdy", {31'd0, in_rdy}, {31'd0, mPhase == 0});
      checkOutput("model_out_val", {31'd0, out_val}, {31'd0, mPhase == 2});
      if (mPhase == 2) checkOutput("model_out", out, mOut);
    end
  end

  // Issue one op from IDLE, measure latency, optionally stall the result.
  task automatic applyStimulus(input logic [1:0] o, input logic [NBITS-1:0] a,
                               input logic [NBITS-1:0] b, input int hold,
                               output logic [NBITS-1:0] res, output int lat);
    int guard;
    guard = 0;
    while (!in_rdy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    op = o; in0 = a; in1 = b; in_val = 1'b1;
    out_rdy = (hold == 0);
    @(negedge clk);
    in_val = 1'b0;
    op = 2'($urandom); in0 = $urandom; in1 = $urandom;
    lat = 1;
    while (!out_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    if (!out_val) checkOutput("result_timeout", {31'd0, out_val}, 32'd1);
    res = out;
    for (int i = 0; i < hold; i++) begin
      in_val = i[0];
      in0 = $urandom;
      @(negedge clk);
      checkOutput("hold_out_val", {31'd0, out_val}, 32'd1);
      checkOutput("hold_out", out, res);
      checkOutput("hold_in_rdy", {31'd0, in_rdy}, 32'd0);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [NBITS-1:0] res;
    int lat;
    int expLat;

    cmpEn = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("reset_in_rdy", {31'd0, in_rdy}, 32'd1);
    checkOutput("reset_out_val", {31'd0, out_val}, 32'd0);
    checkOutput("reset_out", out, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single-cycle ops.
    applyStimulus(OpAdd, 32'd7, 32'd5, 0, res, lat);
    checkOutput("add_7_5", res, 32'd12);
    checkOutput("add_latency", lat, 32'd1);
    checkOutput("add_in_rdy_back", {31'd0, in_rdy}, 32'd1);
    applyStimulus(OpSub, 32'd3, 32'd5, 0, res, lat);
    checkOutput("sub_3_5", res, 32'hFFFF_FFFE);
    applyStimulus(OpAdd, 32'hFFFF_FFFF, 32'd1, 0, res, lat);
    checkOutput("add_wrap", res, 32'd0);
    applyStimulus(OpSub, 32'd0, 32'd1, 0, res, lat);
    checkOutput("sub_wrap", res, 32'hFFFF_FFFF);
    applyStimulus(OpEq, 32'd9, 32'd9, 0, res, lat);
    checkOutput("eq_9_9", res, 32'd1);
    applyStimulus(OpEq, 32'd9, 32'd8, 0, res, lat);
    checkOutput("eq_9_8", res, 32'd0);

    // Multiply results and latencies.
    applyStimulus(OpMul, 32'h1234, 32'h10, 0, res, lat);
    checkOutput("mul_1234_10", res, 32'h12340);
`ifdef ITER_ALU_MUL_EARLY_EXIT_EN
    expLat = 6;
`else
    expLat = 33;
`endif
    checkOutput("mul_1234_latency", lat, expLat);
    applyStimulus(OpMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, res, lat);
    checkOutput("mul_ones", res, 32'd1);
    checkOutput("mul_ones_latency", lat, 32'd33);
    applyStimulus(OpMul, 32'd5, 32'd0, 0, res, lat);
    checkOutput("mul_by_zero", res, 32'd0);
`ifdef ITER_ALU_MUL_EARLY_EXIT_EN
    expLat = 2;
`else
    expLat = 33;
`endif
    checkOutput("mul_by_zero_latency", lat, expLat);

    // Stalled result with in_val pulses during DONE.
    applyStimulus(OpMul, 32'd6, 32'd7, 10, res, lat);
    checkOutput("mul_6_7_stalled", res, 32'd42);

    // Reset in the 5th CALC cycle.
    op = OpMul; in0 = 32'd6; in1 = 32'hFFFF_FFFF; in_val = 1'b1; out_rdy = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_out_val", {31'd0, out_val}, 32'd0);
    checkOutput("midreset_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(OpAdd, 32'd1, 32'd1, 0, res, lat);
    checkOutput("post_reset_add", res, 32'd2);

    // Back-to-back random traffic with random backpressure.
    for (int c = 0; c < 4000; c++) begin
      in_val  = ($urandom_range(0, 3) != 0);
      op      = 2'($urandom);
      in0     = $urandom;
      in1     = $urandom >> $urandom_range(0, 31);
      out_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    in_val = 1'b0;
    out_rdy = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("drain_in_rdy", {31'd0, in_rdy}, 32'd1);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
